// File: rtl/ad5263_spi_tx.sv
// ad5263_spi_tx: turns per-channel wiper writes into 10-bit AD5263 SPI frames {addr[1:0], data[7:0]}, MSB first.
// Latency: a frame launches the cycle after its pending flag is seen in IDLE; CS_N is low for 21*CLK_DIV cycles.
// Backpressure: none; writes during a frame set pending flags and are sent later with the data present at launch.
// Option: define AD5263_SPI_SHADOW_EN to add sent_data and skip frames that would resend an unchanged value.
module ad5263_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] wiper_data,
  input  logic [3:0]  wiper_wr,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        done
`ifdef AD5263_SPI_SHADOW_EN
  ,
  output logic [31:0] sent_data
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [9:0] shreg, shreg_nxt;
  logic       sclk_nxt, mosi_nxt, cs_n_nxt, done_nxt;
  logic [3:0] pend_clr;
  logic [1:0] sel;
  logic [7:0] sel_dat;
  logic       skip;

  // Lowest-numbered pending channel wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel = 2'(i);
    end
  end

  assign sel_dat = wiper_data[{sel, 3'b000} +: 8];
  assign busy    = (state != IDLE);

`ifdef AD5263_SPI_SHADOW_EN
  assign skip = (sel_dat == sent_data[{sel, 3'b000} +: 8]);
`else
  assign skip = 1'b0;
`endif

  // Next-state and output logic: SETUP, then 10 HI/LO pairs, then GAP.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    sclk_nxt    = spi_sclk;
    mosi_nxt    = spi_mosi;
    cs_n_nxt    = spi_cs_n;
    done_nxt    = 1'b0;
    pend_clr    = 4'b0000;
    case (state)
      IDLE: begin
        if (|pending) begin
          pend_clr[sel] = 1'b1;
          if (!skip) begin
            state_nxt   = SETUP;
            cnt_nxt     = 8'd0;
            bit_cnt_nxt = 4'd0;
            shreg_nxt   = {sel, sel_dat};
            mosi_nxt    = sel[1];
            cs_n_nxt    = 1'b0;
          end
        end
      end
      SETUP: begin
        if (cnt == DIV_LAST) begin
          state_nxt   = SCLK_HI;
          cnt_nxt     = 8'd0;
          sclk_nxt    = 1'b1;
          bit_cnt_nxt = bit_cnt + 4'd1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SCLK_HI: begin
        if (cnt == DIV_LAST) begin
          state_nxt = SCLK_LO;
          cnt_nxt   = 8'd0;
          sclk_nxt  = 1'b0;
          shreg_nxt = {shreg[8:0], 1'b0};
          mosi_nxt  = shreg[8];
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SCLK_LO: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt = 8'd0;
          if (bit_cnt == 4'd10) begin
            state_nxt = GAP;
            cs_n_nxt  = 1'b1;
            mosi_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt   = SCLK_HI;
            sclk_nxt    = 1'b1;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and pending registers; a new strobe beats a same-cycle launch clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      bit_cnt  <= 4'd0;
      shreg    <= 10'd0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
      done     <= 1'b0;
      pending  <= 4'b0000;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      spi_sclk <= sclk_nxt;
      spi_mosi <= mosi_nxt;
      spi_cs_n <= cs_n_nxt;
      done     <= done_nxt;
      pending  <= (pending & ~pend_clr) | wiper_wr;
    end
  end

`ifdef AD5263_SPI_SHADOW_EN
  logic [9:0] frame;

  // Remember the launched frame and commit it to the shadow only when it completes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame     <= 10'd0;
      sent_data <= 32'd0;
    end else begin
      if (state == IDLE && state_nxt == SETUP) frame <= {sel, sel_dat};
      if (done_nxt) sent_data[{frame[9:8], 3'b000} +: 8] <= frame[7:0];
    end
  end
`endif

endmodule
